// File: rtl/arb_pkg.sv
// Shared constants and state type for the 8-way round-robin arbiter.
package arb_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;
  localparam int CNT_W = 4;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

endpackage

// File: rtl/arb_onehot_dec.sv
// Combinational 3-to-8 decoder: binary owner index -> one-hot grant vector.
module arb_onehot_dec
  import arb_pkg::*;
(
  input  logic [IDX_W-1:0] idx,
  output logic [N_REQ-1:0] onehot
);

  // Exactly one bit set, selected by idx.
  always_comb begin
    onehot      = '0;
    onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/rr_arbiter8.sv
// 8-way round-robin arbiter with registered one-hot grant and per-grant hold
// counter that forces release after MAX_HOLD cycles.
// Optional macro ARB_LOCK_EN adds a 'lock' input that suspends the timeout
// while asserted; the owner then keeps the grant until its request drops.
//
// Request/grant semantics: req[i] is a level request (not latched). A grant
// appears one edge after req is sampled; the owner keeps it while its req
// stays high and the hold limit has not been reached. On release the search
// restarts just past the previous owner, so the handoff has no idle cycle.
module rr_arbiter8
  import arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
`ifdef ARB_LOCK_EN
  input  logic             lock,
`endif
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid,
  output logic [CNT_W-1:0] hold_cnt
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_HOLD);

  // FSM state kept as a named signal so checkers can bind to it.
  arb_state_e       state;
  arb_state_e       state_n;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] ptr_n;
  logic [IDX_W-1:0] idx_n;
  logic [CNT_W-1:0] cnt_n;
  logic [IDX_W-1:0] base;
  logic [IDX_W-1:0] win;
  logic             found;
  logic             timeout;
  logic             rel;
  logic [N_REQ-1:0] dec;

`ifdef ARB_LOCK_EN
  assign timeout = (hold_cnt >= MAX_CNT) && !lock;
`else
  assign timeout = (hold_cnt >= MAX_CNT);
`endif

  // Owner gives up the grant when its request drops or its time is up.
  assign rel = !req[grant_idx] || timeout;

  // On a release the search starts just after the current owner, which puts
  // the owner's own bit last; when idle it starts at the stored pointer.
  assign base = (state == ARB_BUSY) ? grant_idx + IDX_W'(1) : ptr;

  // Rotating priority search: first requester at or after base, mod 8.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && req[base + IDX_W'(k)]) begin
        found = 1'b1;
        win   = base + IDX_W'(k);
      end
    end
  end

  // Next-state, next owner, next hold count and pointer update.
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    idx_n   = grant_idx;
    cnt_n   = hold_cnt;
    case (state)
      ARB_IDLE: begin
        if (found) begin
          state_n = ARB_BUSY;
          idx_n   = win;
          cnt_n   = CNT_W'(1);
        end else begin
          idx_n = '0;
          cnt_n = '0;
        end
      end
      ARB_BUSY: begin
        if (!rel) begin
          // Saturate: only reachable past MAX_HOLD when the timeout is locked off.
          if (hold_cnt < MAX_CNT) begin
            cnt_n = hold_cnt + CNT_W'(1);
          end
        end else begin
          ptr_n = grant_idx + IDX_W'(1);
          if (found) begin
            idx_n = win;
            cnt_n = CNT_W'(1);
          end else begin
            state_n = ARB_IDLE;
            idx_n   = '0;
            cnt_n   = '0;
          end
        end
      end
      default: begin
        state_n = ARB_IDLE;
        idx_n   = '0;
        cnt_n   = '0;
      end
    endcase
  end

  arb_onehot_dec u_dec (
    .idx    (idx_n),
    .onehot (dec)
  );

  // State and registered outputs; synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ARB_IDLE;
      ptr         <= '0;
      grant_idx   <= '0;
      hold_cnt    <= '0;
      grant_valid <= 1'b0;
      grant       <= '0;
    end else begin
      state       <= state_n;
      ptr         <= ptr_n;
      grant_idx   <= idx_n;
      hold_cnt    <= cnt_n;
      grant_valid <= (state_n == ARB_BUSY);
      grant       <= (state_n == ARB_BUSY) ? dec : '0;
    end
  end

endmodule

// File: tb/tb_rr_arbiter8.sv
// Self-checking bench for rr_arbiter8: directed table, hand sequences for
// rotation/lock, and randomized traffic against a behavioural model.
// Honours ARB_LOCK_EN when defined.
module tb_rr_arbiter8;

  localparam int MAX_HOLD = 10;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req = 8'h00;
  logic       lock = 1'b0;
  logic [7:0] grant;
  logic [2:0] grant_idx;
  logic       grant_valid;
  logic [3:0] hold_cnt;

  always #5 clk = ~clk;

  rr_arbiter8 #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
`ifdef ARB_LOCK_EN
    .lock        (lock),
`endif
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid),
    .hold_cnt    (hold_cnt)
  );

  // ---------------- scoreboard ----------------
  int n_cmp  = 0;
  int n_fail = 0;
  logic [15:0] exp_q[$];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got grant=%h idx=%0d valid=%0d cnt=%0d, expected grant=%h idx=%0d valid=%0d cnt=%0d",
               name, $time, act[15:8], act[7:5], act[4], act[3:0],
               exp[15:8], exp[7:5], exp[4], exp[3:0]);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // owner = -1 means nobody holds the resource.
  int m_owner = -1;
  int m_hold  = 0;
  int m_ptr   = 0;

  function automatic int first_from(input logic [7:0] r, input int start);
    for (int k = 0; k < 8; k++) begin
      if (r[(start + k) % 8]) return (start + k) % 8;
    end
    return -1;
  endfunction

  function automatic logic [15:0] model_word();
    logic [7:0] g;
    g = 8'h00;
    if (m_owner < 0) return 16'h0000;
    g[m_owner] = 1'b1;
    return {g, 3'(m_owner), 1'b1, 4'(m_hold)};
  endfunction

  task automatic model_step(input logic [7:0] r, input logic rn, input logic lk);
    int  w;
    bit  lock_eff;
    bit  expired;
`ifdef ARB_LOCK_EN
    lock_eff = lk;
`else
    lock_eff = 1'b0;
    if (lk) lock_eff = 1'b0;
`endif
    if (!rn) begin
      m_owner = -1; m_hold = 0; m_ptr = 0;
    end else if (m_owner < 0) begin
      w = first_from(r, m_ptr);
      if (w >= 0) begin m_owner = w; m_hold = 1; end
    end else begin
      expired = (m_hold >= MAX_HOLD) && !lock_eff;
      if (r[m_owner] && !expired) begin
        if (m_hold < MAX_HOLD) m_hold = m_hold + 1;
      end else begin
        m_ptr = (m_owner + 1) % 8;
        w = first_from(r, m_ptr);
        if (w >= 0) begin m_owner = w; m_hold = 1; end
        else begin m_owner = -1; m_hold = 0; end
      end
    end
  endtask

  // ---------------- driver ----------------
  // Drive on the falling edge, let the rising edge sample, compare 1 ns later.
  task automatic tick(input logic [7:0] r, input logic rn);
    logic [15:0] e;
    @(negedge clk);
    req   = r;
    rst_n = rn;
    @(posedge clk);
    model_step(r, rn, lock);
    exp_q.push_back(model_word());
    #1;
    e = exp_q.pop_front();
    check("model", {grant, grant_idx, grant_valid, hold_cnt}, e);
  endtask

  function automatic logic [15:0] dut_word();
    return {grant, grant_idx, grant_valid, hold_cnt};
  endfunction

  // ---------------- directed table ----------------
  typedef struct {
    logic [7:0] req;
    logic       rst_n;
    logic [7:0] grant;
    logic [2:0] idx;
    logic       valid;
    logic [3:0] cnt;
    string      name;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic [7:0] r, input logic rn, input logic [7:0] g,
                              input logic [2:0] i, input logic v, input logic [3:0] c,
                              input string nm);
    vec_t t;
    t.req = r; t.rst_n = rn; t.grant = g; t.idx = i; t.valid = v; t.cnt = c; t.name = nm;
    return t;
  endfunction

  initial begin
    logic [15:0] exp_w;
    logic [7:0]  g;
    int          ix;
    logic [7:0]  rr;

    // Reset state and reset dropping a grant mid-hold.
    tbl.push_back(mk(8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 4'd0, "reset_state"));
    tbl.push_back(mk(8'h04, 1'b1, 8'h04, 3'd2, 1'b1, 4'd1, "mid_hold_1"));
    tbl.push_back(mk(8'h04, 1'b1, 8'h04, 3'd2, 1'b1, 4'd2, "mid_hold_2"));
    tbl.push_back(mk(8'h04, 1'b1, 8'h04, 3'd2, 1'b1, 4'd3, "mid_hold_3"));
    tbl.push_back(mk(8'h04, 1'b0, 8'h00, 3'd0, 1'b0, 4'd0, "reset_mid_hold"));
    // Single requester: count 1..10, then self re-grant at the limit.
    for (int c = 1; c <= 10; c++)
      tbl.push_back(mk(8'h01, 1'b1, 8'h01, 3'd0, 1'b1, 4'(c), "single_hold"));
    tbl.push_back(mk(8'h01, 1'b1, 8'h01, 3'd0, 1'b1, 4'd1, "single_regrant"));
    tbl.push_back(mk(8'h01, 1'b1, 8'h01, 3'd0, 1'b1, 4'd2, "single_after"));
    // Early release of owner 7 with pointer wrap to 0.
    tbl.push_back(mk(8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 4'd0, "reset_b"));
    tbl.push_back(mk(8'h80, 1'b1, 8'h80, 3'd7, 1'b1, 4'd1, "own7_1"));
    tbl.push_back(mk(8'h81, 1'b1, 8'h80, 3'd7, 1'b1, 4'd2, "own7_2"));
    tbl.push_back(mk(8'h81, 1'b1, 8'h80, 3'd7, 1'b1, 4'd3, "own7_3"));
    tbl.push_back(mk(8'h01, 1'b1, 8'h01, 3'd0, 1'b1, 4'd1, "wrap_handoff"));
    // Return to idle, then pointer-based priority after owner 2 left.
    tbl.push_back(mk(8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 4'd0, "reset_c"));
    tbl.push_back(mk(8'h04, 1'b1, 8'h04, 3'd2, 1'b1, 4'd1, "own2"));
    tbl.push_back(mk(8'h00, 1'b1, 8'h00, 3'd0, 1'b0, 4'd0, "idle_return"));
    tbl.push_back(mk(8'h00, 1'b1, 8'h00, 3'd0, 1'b0, 4'd0, "idle_stay"));
    tbl.push_back(mk(8'h09, 1'b1, 8'h08, 3'd3, 1'b1, 4'd1, "ptr_priority"));
    tbl.push_back(mk(8'h01, 1'b1, 8'h01, 3'd0, 1'b1, 4'd1, "ptr_wrap_search"));

    // Hold reset a few cycles before starting.
    repeat (2) tick(8'h00, 1'b0);

    foreach (tbl[k]) begin
      tick(tbl[k].req, tbl[k].rst_n);
      check(tbl[k].name, dut_word(), {tbl[k].grant, tbl[k].idx, tbl[k].valid, tbl[k].cnt});
    end

    // Full rotation with all requesters active: each owner exactly MAX_HOLD
    // cycles, in index order, wrapping back to 0, no gaps.
    tick(8'h00, 1'b0);
    for (int k = 0; k < 8 * MAX_HOLD + MAX_HOLD; k++) begin
      tick(8'hFF, 1'b1);
      ix = (k / MAX_HOLD) % 8;
      g = 8'h00;
      g[ix] = 1'b1;
      exp_w = {g, 3'(ix), 1'b1, 4'((k % MAX_HOLD) + 1)};
      check("rotation", dut_word(), exp_w);
    end

`ifdef ARB_LOCK_EN
    // Lock suspends the timeout; count saturates; dropping lock hands off.
    tick(8'h00, 1'b0);
    lock = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      tick(8'h03, 1'b1);
      check("lock_hold", dut_word(),
            {8'h01, 3'd0, 1'b1, 4'((k < MAX_HOLD) ? k : MAX_HOLD)});
    end
    lock = 1'b0;
    tick(8'h03, 1'b1);
    check("lock_release", dut_word(), {8'h02, 3'd1, 1'b1, 4'd1});
`endif

    // Randomized traffic: requests change occasionally so that long holds
    // and timeouts occur, with sporadic resets and sparse patterns.
    tick(8'h00, 1'b0);
    rr = 8'h00;
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 3))
          0: rr = 8'h00;
          1: rr = 8'($urandom) & 8'($urandom);
          2: rr = 8'h01 << $urandom_range(0, 7);
          default: rr = 8'($urandom);
        endcase
      end
`ifdef ARB_LOCK_EN
      if ($urandom_range(0, 15) == 0) lock = ~lock;
`endif
      tick(rr, ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
